instr_fetch_stage: RTL

Instruction-fetch front end for the 4-stage pipeline: owns the program counter, issues word-addressed reads to a synchronous instruction memory, and delivers `{pc, instr}` pairs to the IF/ID register through a valid/ready handshake. It sits directly upstream of IF/ID and replaces the free-running PC with a stall-aware, redirectable fetch path. A 2-entry output buffer absorbs the one-cycle memory latency, so the stage sustains one instruction per cycle while IF/ID is ready.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 91 +++++++++
 rtl/instr_fetch_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch widths, reset PC and the {pc, instr}
// fetch packet handed from instruction fetch to the IF/ID register.
package pipeline_pkg;

    localparam int unsigned ISIZE = 32;
    localparam int unsigned WSIZE = 32;
    localparam logic [ISIZE-1:0] RESET_PC = '0;

    // Fetch packet as seen by IF/ID
    typedef struct packed {
        logic [ISIZE-1:0] pc;
        logic [WSIZE-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO with push, pop and clear and a
// registered head, so the head data never combinationally follows push_data.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         drop all entries (wins over push/pop)
//   push, push_data  write one entry; the caller guarantees room
//   pop           remove the head entry (ignored when empty)
//   valid         registered, count != 0
//   head          registered head entry
//   count         occupancy 0..2
module fetch_fifo #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          valid_q, valid_d;
    logic          pop_eff;

    // Next-state for the two storage slots; head always holds the oldest entry
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop_eff = pop && (count_q != 2'd0);
        if (clear) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = push_data;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop_eff) begin
                        head_d = push_data;
                    end else if (push) begin
                        tail_d  = push_data;
                        count_d = 2'd2;
                    end else if (pop_eff) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop_eff) begin
                        head_d = tail_q;
                        if (push) begin
                            tail_d = push_data;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC owner and fetch issue logic. Issues word-addressed
// reads to a 1-cycle synchronous instruction memory and buffers the returned
// {pc, instr} pairs in a 2-entry FIFO feeding IF/ID over valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req, imem_addr      memory read request / word address (= pc)
//   imem_rdata               read data, one cycle after imem_req
//   redirect, redirect_pc    flush and restart fetch at redirect_pc
//   out_valid, out_ready     handshake towards IF/ID
//   out_instr, out_pc        fetched word and its address
module instr_fetch_stage #(
    parameter int unsigned ISIZE = pipeline_pkg::ISIZE,
    parameter int unsigned WSIZE = pipeline_pkg::WSIZE,
    parameter logic [ISIZE-1:0] RESET_PC = ISIZE'(pipeline_pkg::RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [WSIZE-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WSIZE-1:0] out_instr,
    output logic [ISIZE-1:0] out_pc
);

    localparam int unsigned DW = ISIZE + WSIZE;

    logic [ISIZE-1:0] pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [ISIZE-1:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]    count;
    logic          pop_c;
    logic          push_c;
    logic [2:0]    occ_c;
    logic [DW-1:0] head;

    assign pop_c = out_valid && out_ready;

    // Slots committed after this cycle: entries left after a pop plus the
    // response still in flight. Counting the pop keeps one fetch per cycle.
    assign occ_c = 3'(count) - 3'(pop_c) + 3'(inflight_q);

    assign imem_req  = !rst && !redirect && (occ_c < 3'd2);
    assign imem_addr = pc_q;

    // A response landing in a redirect cycle belongs to the old stream
    assign push_c = inflight_q && !redirect;

    // PC and in-flight tracking
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d          = pc_q + ISIZE'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DW(DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push_c),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (pop_c),
        .valid     (out_valid),
        .head      (head),
        .count     (count)
    );

    assign out_pc    = head[DW-1:WSIZE];
    assign out_instr = head[WSIZE-1:0];

endmodule
